// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared constants, types and helpers for the decade divider
package clock_div_pkg;

  localparam int MAX_STAGES = 16;

  typedef logic [15:0] stage_cnt_t;

  function automatic int cw_of(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/decade_stage.sv
// decade_stage: one divide-by-DIV counter slice with registered tick and square outputs
// Optional macro CLOCK_DIV_OUT_RETIME_EN adds one output register stage (2-cycle latency).
module decade_stage
  import clock_div_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic SYNC_CLR,
  input  logic inc_in,
  output logic wrap_out,
  output logic tick,
  output logic sq
);

  localparam int CW = cw_of(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          r_sq;
  logic          w_clr;

  assign w_clr    = RESET || SYNC_CLR;
  assign wrap_out = inc_in && (r_cnt == LAST);

  // count enabled cycles and register tick/square from the pre-edge count
  always_ff @(posedge CLOCK) begin
    if (w_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
    end else begin
      r_tick <= wrap_out;
      r_sq   <= r_cnt >= HALF;
      if (inc_in) r_cnt <= wrap_out ? '0 : r_cnt + CW'(1);
    end
  end

`ifdef CLOCK_DIV_OUT_RETIME_EN
  logic r_tick_d;
  logic r_sq_d;

  // extra output register for long fanout; cleared with the counters
  always_ff @(posedge CLOCK) begin
    if (w_clr) begin
      r_tick_d <= 1'b0;
      r_sq_d   <= 1'b0;
    end else begin
      r_tick_d <= r_tick;
      r_sq_d   <= r_sq;
    end
  end

  assign tick = r_tick_d;
  assign sq   = r_sq_d;
`else
  assign tick = r_tick;
  assign sq   = r_sq;
`endif

endmodule

// File: rtl/clock_div_decade_gen.sv
// clock_div_decade_gen: N_STAGES cascaded synchronous divide-by-DIV tick/square generator
// Optional macro CLOCK_DIV_OUT_RETIME_EN retimes TICK/SQ through one more register.
module clock_div_decade_gen
  import clock_div_pkg::*;
#(
  parameter int N_STAGES = 7,
  parameter int DIV      = 10
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                CE,
  input  logic                SYNC_CLR,
  output logic [N_STAGES-1:0] TICK,
  output logic [N_STAGES-1:0] SQ
);

  if (DIV < 2 || N_STAGES < 1 || N_STAGES > MAX_STAGES) begin : g_bad_params
    $fatal(1, "clock_div_decade_gen: DIV must be >= 2 and N_STAGES in 1..16");
  end

  logic [N_STAGES:0] w_inc;
  logic              w_unused_carry;

  assign w_inc[0]       = CE;
  assign w_unused_carry = w_inc[N_STAGES];

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    decade_stage #(.DIV(DIV)) u_stage (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .SYNC_CLR(SYNC_CLR),
      .inc_in  (w_inc[k]),
      .wrap_out(w_inc[k+1]),
      .tick    (TICK[k]),
      .sq      (SQ[k])
    );
  end

endmodule
